// File: rtl/exe_pkg.sv
// Shared types and constants for the exe_arbiter / exe_unit slice.
// Opcodes outside OP_ADD..OP_SHR make exe_unit pass argA through.
package exe_pkg;

   localparam int M_DEF = 8;
   localparam int N_DEF = 4;

   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_AND = 2;
   localparam int OP_OR  = 3;
   localparam int OP_XOR = 4;
   localparam int OP_NOT = 5;
   localparam int OP_SHL = 6;
   localparam int OP_SHR = 7;

   typedef struct packed {
      logic vf;
      logic pf;
      logic bf;
      logic zf;
   } flags_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_t;

   typedef logic gid_t;

endpackage

// File: rtl/exe_unit.sv
// Combinational ALU shared by both requesters of exe_arbiter.
// BF is carry/borrow (or the bit shifted out), PF is set for an even number of ones.
module exe_unit
   import exe_pkg::*;
#(
   parameter int M = M_DEF,
   parameter int N = N_DEF
) (
   input  logic [M-1:0] i_argA,
   input  logic [M-1:0] i_argB,
   input  logic [N-1:0] i_oper,
   output logic [M-1:0] o_result,
   output logic         o_ZF,
   output logic         o_BF,
   output logic         o_PF,
   output logic         o_VF
);

   logic [M:0]   ext;
   logic [M-1:0] result;
   logic         bf;
   logic         vf;

   always_comb begin
      ext    = '0;
      result = i_argA;
      bf     = 1'b0;
      vf     = 1'b0;
      case (i_oper)
         N'(OP_ADD): begin
            ext    = {1'b0, i_argA} + {1'b0, i_argB};
            result = ext[M-1:0];
            bf     = ext[M];
            vf     = (i_argA[M-1] == i_argB[M-1]) && (result[M-1] != i_argA[M-1]);
         end
         N'(OP_SUB): begin
            // The borrow appears as the wrapped top bit of the widened difference.
            ext    = {1'b0, i_argA} - {1'b0, i_argB};
            result = ext[M-1:0];
            bf     = ext[M];
            vf     = (i_argA[M-1] != i_argB[M-1]) && (result[M-1] != i_argA[M-1]);
         end
         N'(OP_AND): result = i_argA & i_argB;
         N'(OP_OR):  result = i_argA | i_argB;
         N'(OP_XOR): result = i_argA ^ i_argB;
         N'(OP_NOT): result = ~i_argA;
         N'(OP_SHL): begin
            result = {i_argA[M-2:0], 1'b0};
            bf     = i_argA[M-1];
         end
         N'(OP_SHR): begin
            result = {1'b0, i_argA[M-1:1]};
            bf     = i_argA[0];
         end
         default: result = i_argA;
      endcase
   end

   assign o_result = result;
   assign o_ZF     = (result == '0);
   assign o_BF     = bf;
   assign o_PF     = ~^result;
   assign o_VF     = vf;

endmodule

// File: rtl/exe_arbiter.sv
// Round-robin arbiter sequencing two valid/ready requesters onto one exe_unit.
// One operation in flight: IDLE accepts, EXEC captures the ALU, RESP hands the result back.
module exe_arbiter
   import exe_pkg::*;
#(
   parameter int M = M_DEF,
   parameter int N = N_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_req0_valid,
   output logic         o_req0_ready,
   input  logic [M-1:0] i_req0_argA,
   input  logic [M-1:0] i_req0_argB,
   input  logic [N-1:0] i_req0_oper,
   input  logic         i_req1_valid,
   output logic         o_req1_ready,
   input  logic [M-1:0] i_req1_argA,
   input  logic [M-1:0] i_req1_argB,
   input  logic [N-1:0] i_req1_oper,
   output logic         o_rsp0_valid,
   input  logic         i_rsp0_ready,
   output logic         o_rsp1_valid,
   input  logic         i_rsp1_ready,
   output logic [M-1:0] o_result,
   output logic [3:0]   o_flags,
   output logic         o_busy
);

   arb_state_t   state_q, state_d;
   gid_t         rr_q, rr_d;
   gid_t         grant_id;
   gid_t         gid_p0;
   logic         accept;
   logic         rsp_done;

   logic [M-1:0] arg_a_p0, arg_b_p0;
   logic [N-1:0] oper_p0;

   logic [M-1:0] alu_result;
   logic         alu_zf, alu_bf, alu_pf, alu_vf;
   flags_t       alu_flags;

   logic [M-1:0] result_p1;
   flags_t       flags_p1;

   // Reset gates every handshake output so a dropped operation never shows up.
   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      grant_id     = rr_q;
      accept       = 1'b0;
      rsp_done     = 1'b0;
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
      o_rsp0_valid = 1'b0;
      o_rsp1_valid = 1'b0;
      if (!i_rst) begin
         unique case (state_q)
            IDLE: begin
               if (i_req0_valid && i_req1_valid) begin
                  grant_id = rr_q;
               end else begin
                  grant_id = i_req1_valid;
               end
               if (i_req0_valid || i_req1_valid) begin
                  accept       = 1'b1;
                  o_req0_ready = !grant_id;
                  o_req1_ready = grant_id;
                  state_d      = EXEC;
               end
            end
            EXEC: state_d = RESP;
            RESP: begin
               o_rsp0_valid = !gid_p0;
               o_rsp1_valid = gid_p0;
               rsp_done     = gid_p0 ? i_rsp1_ready : i_rsp0_ready;
               // The pointer only moves once the response has been taken.
               if (rsp_done) begin
                  rr_d    = ~gid_p0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
      end
   end

   // Stage p0: operands of the granted requester, sampled on the accept cycle only.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         arg_a_p0 <= grant_id ? i_req1_argA : i_req0_argA;
         arg_b_p0 <= grant_id ? i_req1_argB : i_req0_argB;
         oper_p0  <= grant_id ? i_req1_oper : i_req0_oper;
         gid_p0   <= grant_id;
      end
   end

   exe_unit #(
      .M(M),
      .N(N)
   ) u_exe_unit (
      .i_argA   (arg_a_p0),
      .i_argB   (arg_b_p0),
      .i_oper   (oper_p0),
      .o_result (alu_result),
      .o_ZF     (alu_zf),
      .o_BF     (alu_bf),
      .o_PF     (alu_pf),
      .o_VF     (alu_vf)
   );

   assign alu_flags = '{vf: alu_vf, pf: alu_pf, bf: alu_bf, zf: alu_zf};

   // Stage p1: ALU output held stable for the whole RESP phase.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         result_p1 <= '0;
         flags_p1  <= '0;
      end else if (state_q == EXEC) begin
         result_p1 <= alu_result;
         flags_p1  <= alu_flags;
      end
   end

   assign o_result = result_p1;
   assign o_flags  = flags_p1;
   assign o_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_exe_arbiter.sv
// Bench for exe_arbiter: ALU vector table, hand-written handshake/reset sequences,
// and a randomized run scored by a cycle monitor with an integer-arithmetic ALU model.
module tb_exe_arbiter;

   logic       clk;
   logic       rst;
   logic       req_v   [2];
   logic [7:0] req_a   [2];
   logic [7:0] req_b   [2];
   logic [3:0] req_op  [2];
   logic       rsp_rdy [2];

   logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
   logic [7:0] result;
   logic [3:0] flags;

   logic [7:0] g_a, g_b, g_r;
   logic [3:0] g_op;
   logic       g_zf, g_bf, g_pf, g_vf;

   int errors = 0;
   int checks = 0;

   exe_arbiter #(.M(8), .N(4)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req0_valid (req_v[0]),
      .o_req0_ready (req0_ready),
      .i_req0_argA  (req_a[0]),
      .i_req0_argB  (req_b[0]),
      .i_req0_oper  (req_op[0]),
      .i_req1_valid (req_v[1]),
      .o_req1_ready (req1_ready),
      .i_req1_argA  (req_a[1]),
      .i_req1_argB  (req_b[1]),
      .i_req1_oper  (req_op[1]),
      .o_rsp0_valid (rsp0_valid),
      .i_rsp0_ready (rsp_rdy[0]),
      .o_rsp1_valid (rsp1_valid),
      .i_rsp1_ready (rsp_rdy[1]),
      .o_result     (result),
      .o_flags      (flags),
      .o_busy       (busy)
   );

   exe_unit #(.M(8), .N(4)) u_gold (
      .i_argA   (g_a),
      .i_argB   (g_b),
      .i_oper   (g_op),
      .o_result (g_r),
      .o_ZF     (g_zf),
      .o_BF     (g_bf),
      .o_PF     (g_pf),
      .o_VF     (g_vf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Reference ALU from plain integer arithmetic; returns {VF,PF,BF,ZF,result}.
   function automatic logic [11:0] alu_ref(int a, int b, int op);
      int r, sa, sb, sr;
      bit bf, vf, zf, pf;
      logic [7:0] r8;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      bf = 0;
      vf = 0;
      case (op)
         0: begin r = a + b; bf = (r > 255); sr = sa + sb; vf = (sr > 127) || (sr < -128); end
         1: begin r = a - b; bf = (r < 0);   sr = sa - sb; vf = (sr > 127) || (sr < -128); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 255 - a;
         6: begin r = a * 2; bf = (a >= 128); end
         7: begin r = a / 2; bf = (a % 2 == 1); end
         default: r = a;
      endcase
      r  = r & 255;
      r8 = r[7:0];
      zf = (r == 0);
      pf = ($countones(r) % 2 == 0);
      return {vf, pf, bf, zf, r8};
   endfunction

   // ---------------- cycle monitor / scoreboard ----------------
   typedef struct {
      int id;
      int cyc;
   } acc_t;

   acc_t        acc_log [$];
   bit          pend = 0;
   int          pid = 0;
   int          age = 0;
   int          cyc = 0;
   bit          rr_m = 0;
   logic [11:0] exp_rsp;
   int          acc_cnt [2] = '{0, 0};
   int          rsp_cnt [2] = '{0, 0};
   bit          acc_flag [2] = '{0, 0};

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         acc_flag[0] = 0;
         acc_flag[1] = 0;
         if (rst) begin
            chk({req1_ready, req0_ready, rsp1_valid, rsp0_valid} === 4'b0000, "rst_quiet",
                32'({req1_ready, req0_ready, rsp1_valid, rsp0_valid}), 32'd0);
            pend = 0;
            rr_m = 0;
         end else begin
            chk(busy === pend, "busy", 32'(busy), 32'(pend));
            if (!pend) begin
               chk({rsp1_valid, rsp0_valid} === 2'b00, "idle_rsp_valid",
                   32'({rsp1_valid, rsp0_valid}), 32'd0);
               if (req_v[0] || req_v[1]) begin
                  int g;
                  g = (req_v[0] && req_v[1]) ? int'(rr_m) : (req_v[1] ? 1 : 0);
                  chk({req1_ready, req0_ready} === ((g == 1) ? 2'b10 : 2'b01), "grant",
                      32'({req1_ready, req0_ready}), (g == 1) ? 32'd2 : 32'd1);
                  exp_rsp = alu_ref(int'(req_a[g]), int'(req_b[g]), int'(req_op[g]));
                  pend = 1;
                  pid  = g;
                  age  = 0;
                  acc_cnt[g]++;
                  acc_flag[g] = 1;
                  acc_log.push_back('{g, cyc});
               end else begin
                  chk({req1_ready, req0_ready} === 2'b00, "idle_no_ready",
                      32'({req1_ready, req0_ready}), 32'd0);
               end
            end else begin
               age++;
               chk({req1_ready, req0_ready} === 2'b00, "busy_ready",
                   32'({req1_ready, req0_ready}), 32'd0);
               if (age == 1) begin
                  chk({rsp1_valid, rsp0_valid} === 2'b00, "exec_rsp_valid",
                      32'({rsp1_valid, rsp0_valid}), 32'd0);
               end else begin
                  chk({rsp1_valid, rsp0_valid} === ((pid == 1) ? 2'b10 : 2'b01), "rsp_valid",
                      32'({rsp1_valid, rsp0_valid}), (pid == 1) ? 32'd2 : 32'd1);
                  chk(result === exp_rsp[7:0], "rsp_result", 32'(result), 32'(exp_rsp[7:0]));
                  chk(flags === exp_rsp[11:8], "rsp_flags", 32'(flags), 32'(exp_rsp[11:8]));
                  if (rsp_rdy[pid]) begin
                     pend = 0;
                     rr_m = (pid == 0);
                     rsp_cnt[pid]++;
                  end
               end
            end
         end
      end
   end

   // ---------------- helpers ----------------
   function automatic logic rdy(int id);
      return (id == 0) ? req0_ready : req1_ready;
   endfunction

   function automatic logic rspv(int id);
      return (id == 0) ? rsp0_valid : rsp1_valid;
   endfunction

   // Waits (bounded) for the accept of requester id, then drops its valid.
   task automatic wait_accept(input int id, input string name);
      bit ok = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rdy(id)) begin
            ok = 1;
            break;
         end
      end
      chk(ok, name, 32'(ok), 32'd1);
      @(posedge clk);
      #1 req_v[id] = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      chk(ok, name, 32'(ok), 32'd1);
   endtask

   task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, output logic [7:0] r, output logic [3:0] f);
      bit ok = 0;
      @(posedge clk);
      #1;
      req_a[id]   = a;
      req_b[id]   = b;
      req_op[id]  = op;
      req_v[id]   = 1'b1;
      rsp_rdy[id] = 1'b1;
      wait_accept(id, "op_accept");
      r = '0;
      f = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rspv(id) && rsp_rdy[id]) begin
            ok = 1;
            r  = result;
            f  = flags;
            break;
         end
      end
      chk(ok, "op_response", 32'(ok), 32'd1);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      logic [7:0] r;
      logic [3:0] f;
   } vec_t;

   vec_t vecs [13];

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] r, sv_r;
      logic [3:0] f, sv_f;
      int         base_acc [2];
      int         base_rsp [2];
      int         op_ctr [2];
      bit         stop, drained;

      vecs[0]  = '{8'd100, 8'd27,  4'd0,  8'h7F, 4'h0};
      vecs[1]  = '{8'd100, 8'd28,  4'd0,  8'h80, 4'h8};
      vecs[2]  = '{8'd200, 8'd56,  4'd0,  8'h00, 4'h7};
      vecs[3]  = '{8'd5,   8'd7,   4'd1,  8'hFE, 4'h2};
      vecs[4]  = '{8'h80,  8'h01,  4'd1,  8'h7F, 4'h8};
      vecs[5]  = '{8'd9,   8'd9,   4'd1,  8'h00, 4'h5};
      vecs[6]  = '{8'hF0,  8'h0F,  4'd2,  8'h00, 4'h5};
      vecs[7]  = '{8'hA0,  8'h05,  4'd3,  8'hA5, 4'h4};
      vecs[8]  = '{8'hFF,  8'h0F,  4'd4,  8'hF0, 4'h4};
      vecs[9]  = '{8'h00,  8'h5A,  4'd5,  8'hFF, 4'h4};
      vecs[10] = '{8'h81,  8'h00,  4'd6,  8'h02, 4'h2};
      vecs[11] = '{8'h81,  8'h00,  4'd7,  8'h40, 4'h2};
      vecs[12] = '{8'h33,  8'h77,  4'd12, 8'h33, 4'h4};

      rst  = 1'b1;
      g_a  = '0;
      g_b  = '0;
      g_op = '0;
      for (int i = 0; i < 2; i++) begin
         req_v[i]   = 1'b1;
         req_a[i]   = 8'(17 * (i + 1));
         req_b[i]   = 8'(5 * (i + 1));
         req_op[i]  = 4'(i);
         rsp_rdy[i] = 1'b1;
         op_ctr[i]  = 0;
      end

      // Reset with both valids high, then both always valid: 0,1,0,1... every 3 cycles.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
      chk({req1_ready, req0_ready} === 2'b00, "rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
      chk(result === 8'h00, "rst_result", 32'(result), 32'd0);
      chk(flags === 4'h0, "rst_flags", 32'(flags), 32'd0);
      acc_log.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk({req1_ready, req0_ready} === 2'b01, "first_grant_req0",
          32'({req1_ready, req0_ready}), 32'd1);
      for (int k = 0; k < 80 && acc_log.size() < 10; k++) @(negedge clk);
      chk(acc_log.size() >= 10, "alt_accepts", 32'(acc_log.size()), 32'd10);
      for (int i = 0; i < 10 && i < acc_log.size(); i++) begin
         chk(acc_log[i].id == i % 2, "alt_order", 32'(acc_log[i].id), 32'(i % 2));
         if (i > 0)
            chk(acc_log[i].cyc - acc_log[i-1].cyc == 3, "alt_spacing",
                32'(acc_log[i].cyc - acc_log[i-1].cyc), 32'd3);
      end
      @(posedge clk);
      #1;
      req_v[0] = 1'b0;
      req_v[1] = 1'b0;
      wait_idle("alt_drain");

      // ALU vector table through requester 0, cross-checked against a standalone exe_unit.
      foreach (vecs[i]) begin
         run_op(0, vecs[i].a, vecs[i].b, vecs[i].op, r, f);
         chk(r === vecs[i].r, "vec_result", 32'(r), 32'(vecs[i].r));
         chk(f === vecs[i].f, "vec_flags", 32'(f), 32'(vecs[i].f));
         g_a  = vecs[i].a;
         g_b  = vecs[i].b;
         g_op = vecs[i].op;
         #1;
         chk({g_vf, g_pf, g_bf, g_zf, g_r} === {vecs[i].f, vecs[i].r}, "gold_unit",
             32'({g_vf, g_pf, g_bf, g_zf, g_r}), 32'({vecs[i].f, vecs[i].r}));
      end

      // Single request on requester 1: 33 AND 44.
      @(posedge clk);
      #1;
      req_a[1]   = 8'd33;
      req_b[1]   = 8'd44;
      req_op[1]  = 4'd2;
      req_v[1]   = 1'b1;
      rsp_rdy[1] = 1'b1;
      @(negedge clk);
      chk(req1_ready === 1'b1, "single_ready", 32'(req1_ready), 32'd1);
      @(posedge clk);
      #1 req_v[1] = 1'b0;
      @(negedge clk);
      chk({req1_ready, rsp1_valid} === 2'b00, "single_exec", 32'({req1_ready, rsp1_valid}), 32'd0);
      @(negedge clk);
      chk(rsp1_valid === 1'b1, "single_rsp_valid", 32'(rsp1_valid), 32'd1);
      chk(result === 8'd32, "single_result", 32'(result), 32'd32);
      chk(flags === 4'h0, "single_flags", 32'(flags), 32'd0);
      @(negedge clk);
      chk(rsp1_valid === 1'b0, "single_rsp_drop", 32'(rsp1_valid), 32'd0);

      // Backpressure on response 0 while requester 1 waits.
      @(posedge clk);
      #1;
      rsp_rdy[0] = 1'b0;
      req_a[0]   = 8'd90;
      req_b[0]   = 8'd120;
      req_op[0]  = 4'd1;
      req_v[0]   = 1'b1;
      @(negedge clk);
      chk(req0_ready === 1'b1, "bp_accept0", 32'(req0_ready), 32'd1);
      @(posedge clk);
      #1;
      req_v[0]  = 1'b0;
      req_a[1]  = 8'd3;
      req_b[1]  = 8'd4;
      req_op[1] = 4'd0;
      req_v[1]  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk(rsp0_valid === 1'b1, "bp_rsp_valid", 32'(rsp0_valid), 32'd1);
      sv_r = result;
      sv_f = flags;
      repeat (4) begin
         @(negedge clk);
         chk(rsp0_valid === 1'b1, "bp_hold_valid", 32'(rsp0_valid), 32'd1);
         chk({flags, result} === {sv_f, sv_r}, "bp_hold_data", 32'({flags, result}), 32'({sv_f, sv_r}));
         chk(req1_ready === 1'b0, "bp_req1_wait", 32'(req1_ready), 32'd0);
      end
      @(posedge clk);
      #1 rsp_rdy[0] = 1'b1;
      @(negedge clk);
      chk(rsp0_valid === 1'b1, "bp_complete", 32'(rsp0_valid), 32'd1);
      @(posedge clk);
      #1 rsp_rdy[0] = 1'b0;
      @(negedge clk);
      chk(req1_ready === 1'b1, "bp_req1_grant", 32'(req1_ready), 32'd1);
      @(posedge clk);
      #1;
      req_v[1]   = 1'b0;
      rsp_rdy[0] = 1'b1;
      wait_idle("bp_drain");

      // Reset during EXEC, and then during RESP; rr is left at 1 beforehand each time.
      for (int pass = 0; pass < 2; pass++) begin
         run_op(0, 8'd7, 8'd9, 4'd0, r, f);
         @(posedge clk);
         #1;
         req_a[1]   = 8'd200;
         req_b[1]   = 8'd100;
         req_op[1]  = 4'd0;
         req_v[1]   = 1'b1;
         rsp_rdy[1] = 1'b0;
         @(negedge clk);
         chk(req1_ready === 1'b1, "rstx_accept1", 32'(req1_ready), 32'd1);
         @(posedge clk);
         #1 req_v[1] = 1'b0;
         if (pass == 1) begin
            @(negedge clk);
            @(negedge clk);
            chk(rsp1_valid === 1'b1, "rstx_in_resp", 32'(rsp1_valid), 32'd1);
            @(posedge clk);
            #1;
         end
         rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         chk({busy, rsp1_valid, rsp0_valid} === 3'b000, "rstx_ctrl",
             32'({busy, rsp1_valid, rsp0_valid}), 32'd0);
         chk({flags, result} === 12'h000, "rstx_data", 32'({flags, result}), 32'd0);
         repeat (3) begin
            @(negedge clk);
            chk(rsp1_valid === 1'b0, "rstx_no_rsp", 32'(rsp1_valid), 32'd0);
         end
         rsp_rdy[1] = 1'b1;
         @(posedge clk);
         #1;
         req_v[0] = 1'b1;
         req_v[1] = 1'b1;
         @(negedge clk);
         chk({req1_ready, req0_ready} === 2'b01, "rstx_next_req0",
             32'({req1_ready, req0_ready}), 32'd1);
         @(posedge clk);
         #1 req_v[0] = 1'b0;
         wait_accept(1, "rstx_then_req1");
         wait_idle("rstx_drain");
      end

      // Randomized traffic: valids held until accepted, operands churn every cycle.
      base_acc = acc_cnt;
      base_rsp = rsp_cnt;
      stop     = 0;
      drained  = 0;
      for (int k = 0; k < 20000; k++) begin
         @(posedge clk);
         #1;
         if (acc_cnt[0] + acc_cnt[1] - base_acc[0] - base_acc[1] >= 500) stop = 1;
         for (int i = 0; i < 2; i++) begin
            if (acc_flag[i]) op_ctr[i] = (op_ctr[i] + 1) % 16;
            if (!(req_v[i] && !acc_flag[i]))
               req_v[i] = stop ? 1'b0 : ($urandom_range(0, 99) < 60);
            req_a[i]   = 8'($urandom_range(0, 255));
            req_b[i]   = 8'($urandom_range(0, 255));
            req_op[i]  = 4'(op_ctr[i]);
            rsp_rdy[i] = stop ? 1'b1 : ($urandom_range(0, 99) < 65);
         end
         if (stop && !req_v[0] && !req_v[1] && !busy) begin
            drained = 1;
            break;
         end
      end
      chk(drained, "rand_complete", 32'(drained), 32'd1);
      for (int i = 0; i < 2; i++)
         chk(acc_cnt[i] - base_acc[i] == rsp_cnt[i] - base_rsp[i], "rand_acc_vs_rsp",
             32'(rsp_cnt[i] - base_rsp[i]), 32'(acc_cnt[i] - base_acc[i]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
